// File: rtl/io_access_sequencer.sv
// IO-page access sequencer: stalls the core while a single load/store is carried
// out on one of NDEV memory-mapped devices, with timeout and sticky error reporting.
module io_access_sequencer #(
  parameter int NDEV    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            IORead,
  input  logic            IOWrite,
  input  logic [7:0]      io_addr,
  input  logic [31:0]     io_wdata,
  input  logic            dev_ack,
  input  logic [31:0]     dev_rdata,
  input  logic            err_clr,
  output logic            stall,
  output logic [31:0]     io_rdata,
  output logic            io_rdata_valid,
  output logic [NDEV-1:0] dev_sel,
  output logic            dev_req,
  output logic            dev_we,
  output logic [3:0]      dev_addr,
  output logic [31:0]     dev_wdata,
  output logic            io_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [4:0]      cnt;
  logic [NDEV-1:0] sel_dec;
  logic            mapped;
  logic            start;
  logic            fault;
  logic            ack_rd;

  always_comb begin
    sel_dec = '0;
    for (int i = 0; i < NDEV; i++) sel_dec[i] = (io_addr[7:4] == 4'(i));
  end

  assign mapped = ({28'd0, io_addr[7:4]} < 32'(NDEV));

  // A simultaneous load and store is treated like an unmapped access.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    fault     = 1'b0;
    ack_rd    = 1'b0;
    case (state)
      IDLE: begin
        if (IORead | IOWrite) begin
          if ((IORead ^ IOWrite) && mapped) begin
            start     = 1'b1;
            state_nxt = ACCESS;
          end else begin
            fault     = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      ACCESS: begin
        if (dev_ack) begin
          ack_rd    = ~dev_we;
          state_nxt = DONE;
        end else if (cnt == 5'(TIMEOUT - 1)) begin
          fault     = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign stall          = ((state == IDLE) && (IORead | IOWrite)) || (state == ACCESS);
  assign dev_req        = (state == ACCESS);
  assign io_rdata_valid = (state == DONE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      io_rdata  <= '0;
      dev_sel   <= '0;
      dev_we    <= 1'b0;
      dev_addr  <= '0;
      dev_wdata <= '0;
      io_err    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start) begin
        dev_addr  <= io_addr[3:0];
        dev_wdata <= io_wdata;
        dev_we    <= IOWrite;
        dev_sel   <= sel_dec;
        cnt       <= '0;
      end else if (state == ACCESS) begin
        cnt <= cnt + 5'd1;
      end
      // dev_sel must read all-zero as soon as the access ends.
      if ((state == ACCESS) && (state_nxt != ACCESS)) dev_sel <= '0;
      if (fault)       io_rdata <= '0;
      else if (ack_rd) io_rdata <= dev_rdata;
      // A new error event outranks a simultaneous clear.
      if (fault)        io_err <= 1'b1;
      else if (err_clr) io_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_io_access_sequencer.sv
// Scoreboard bench for io_access_sequencer: expected DONE results are queued when
// an access is issued and compared whenever io_rdata_valid is seen.
module tb_io_access_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        IORead, IOWrite;
  logic [7:0]  io_addr;
  logic [31:0] io_wdata;
  logic        dev_ack;
  logic [31:0] dev_rdata;
  logic        err_clr;
  logic        stall;
  logic [31:0] io_rdata;
  logic        io_rdata_valid;
  logic [3:0]  dev_sel;
  logic        dev_req;
  logic        dev_we;
  logic [3:0]  dev_addr;
  logic [31:0] dev_wdata;
  logic        io_err;

  io_access_sequencer #(.NDEV(4), .TIMEOUT(16)) dut (
    .clock(clock), .reset(reset), .IORead(IORead), .IOWrite(IOWrite),
    .io_addr(io_addr), .io_wdata(io_wdata), .dev_ack(dev_ack), .dev_rdata(dev_rdata),
    .err_clr(err_clr), .stall(stall), .io_rdata(io_rdata), .io_rdata_valid(io_rdata_valid),
    .dev_sel(dev_sel), .dev_req(dev_req), .dev_we(dev_we), .dev_addr(dev_addr),
    .dev_wdata(dev_wdata), .io_err(io_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  int          n_vec  = 0;
  int          n_miss = 0;
  logic [31:0] last_rdata = '0;
  logic        err_model  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (io_rdata_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("done_rdata", io_rdata, e.rdata);
        chk("done_err", 32'(io_err), 32'(e.err));
      end
    end
  end

  // Issue one access starting from IDLE at a negedge; ack_k=0 means never ack.
  task automatic access(input logic rd, input logic wr, input logic [7:0] addr,
                        input logic [31:0] wd, input int ack_k, input logic [31:0] rdat);
    logic        ok;
    int          ncyc, stalls, reqs;
    exp_t        e;
    logic [3:0]  exp_sel;
    ok      = (rd ^ wr) && (addr[7:4] < 4'd4);
    ncyc    = (ack_k >= 1 && ack_k <= 16) ? ack_k : 16;
    exp_sel = 4'b0001 << addr[7:4];
    if (!ok || ack_k < 1 || ack_k > 16) begin
      err_model = 1'b1;
      e.rdata   = '0;
    end else begin
      e.rdata = rd ? rdat : last_rdata;
    end
    last_rdata = e.rdata;
    e.err      = err_model;
    exp_q.push_back(e);

    IORead = rd; IOWrite = wr; io_addr = addr; io_wdata = wd; dev_ack = 1'b0;
    #1;
    chk("stall_idle", 32'(stall), 32'd1);
    stalls = 1;
    reqs   = 0;
    @(negedge clock);
    IORead = 1'b0; IOWrite = 1'b0;
    if (ok) begin
      chk("dev_sel", 32'(dev_sel), 32'(exp_sel));
      chk("dev_addr", 32'(dev_addr), 32'(addr[3:0]));
      chk("dev_we", 32'(dev_we), 32'(wr));
      chk("dev_wdata", dev_wdata, wd);
      for (int k = 1; k <= ncyc; k++) begin
        stalls += int'(stall);
        reqs   += int'(dev_req);
        dev_ack   = (k == ack_k);
        dev_rdata = rdat;
        @(negedge clock);
        dev_ack = 1'b0;
      end
    end
    chk("dev_req_cycles", 32'(reqs), ok ? 32'(ncyc) : 32'd0);
    chk("stall_cycles", 32'(stalls), ok ? 32'(ncyc + 1) : 32'd1);
    chk("stall_done", 32'(stall), 32'd0);
    chk("dev_sel_done", 32'(dev_sel), 32'd0);
    chk("req_done", 32'(dev_req), 32'd0);
    @(negedge clock);
    chk("valid_after_done", 32'(io_rdata_valid), 32'd0);
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    @(negedge clock);
    err_clr   = 1'b0;
    err_model = 1'b0;
    chk("err_cleared", 32'(io_err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timed out");
  end

  initial begin
    reset = 1'b1; IORead = 1'b0; IOWrite = 1'b0; io_addr = '0; io_wdata = '0;
    dev_ack = 1'b0; dev_rdata = '0; err_clr = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_rdata", io_rdata, 32'd0);
    chk("rst_valid", 32'(io_rdata_valid), 32'd0);
    chk("rst_sel", 32'(dev_sel), 32'd0);
    chk("rst_req", 32'(dev_req), 32'd0);
    chk("rst_we", 32'(dev_we), 32'd0);
    chk("rst_addr", 32'(dev_addr), 32'd0);
    chk("rst_wdata", dev_wdata, 32'd0);
    chk("rst_err", 32'(io_err), 32'd0);
    @(negedge clock);

    access(1'b1, 1'b0, 8'h12, 32'h0, 2, 32'hA5A5_0001);
    access(1'b0, 1'b1, 8'h30, 32'h0000_FFFF, 1, 32'h1234_5678);
    access(1'b1, 1'b0, 8'h00, 32'h0, 0, 32'hFFFF_FFFF);
    clear_err();
    access(1'b1, 1'b0, 8'h50, 32'h0, 1, 32'h1111_1111);
    clear_err();
    access(1'b1, 1'b1, 8'h10, 32'h0, 1, 32'h2222_2222);
    clear_err();
    access(1'b1, 1'b0, 8'h25, 32'h0, 16, 32'hDEAD_BEEF);
    chk("ack_boundary_err", 32'(io_err), 32'd0);

    for (int i = 0; i < 6; i++) begin
      logic        r;
      logic [7:0]  a;
      r = 1'($urandom_range(0, 1));
      a = {2'b00, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
      access(r, ~r, a, $urandom, int'($urandom_range(1, 5)), $urandom);
    end

    // Reset on the third ACCESS cycle aborts the access without a DONE pulse.
    IORead = 1'b1; io_addr = 8'h21; dev_ack = 1'b0;
    @(negedge clock);
    IORead = 1'b0;
    repeat (2) @(negedge clock);
    chk("pre_reset_req", 32'(dev_req), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    last_rdata = '0;
    err_model  = 1'b0;
    chk("abort_req", 32'(dev_req), 32'd0);
    chk("abort_stall", 32'(stall), 32'd0);
    chk("abort_err", 32'(io_err), 32'd0);
    chk("abort_sel", 32'(dev_sel), 32'd0);
    repeat (3) @(negedge clock);

    access(1'b1, 1'b0, 8'h33, 32'h0, 3, 32'hCAFE_0003);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/io_access_sequencer.md
IO_ACCESS_SEQUENCER -- requirements
Module: io_access_sequencer

Interface
REQ-001 Parameter NDEV, default 4: number of mapped IO devices.
REQ-002 Parameter TIMEOUT, default 16: maximum ACCESS cycles allowed without dev_ack.
REQ-003 The clock port SHALL be: clock, input, 1 bit; the only clock; all state updates on its rising edge.
REQ-004 The reset port SHALL be: reset, input, 1 bit; synchronous, active-high.
REQ-005 Port: IORead, input, 1 bit; current instruction is a load to the IO page.
REQ-006 Port: IOWrite, input, 1 bit; current instruction is a store to the IO page.
REQ-007 Port: io_addr, input, 8 bits; offset within the IO page. [7:4] selects the device; [3:0] selects the register.
REQ-008 Port: io_wdata, input, 32 bits; store data.
REQ-009 Port: dev_ack, input, 1 bit; the selected device has completed the access.
REQ-010 Port: dev_rdata, input, 32 bits; device read data, valid when dev_ack=1.
REQ-011 Port: err_clr, input, 1 bit; clears the sticky error flag.
REQ-012 Port: stall, output, 1 bit; freezes PC and register writeback.
REQ-013 Port: io_rdata, output, 32 bits; data for the load writeback.
REQ-014 Port: io_rdata_valid, output, 1 bit; io_rdata may be written back this cycle.
REQ-015 Port: dev_sel, output, NDEV bits; one-hot device select.
REQ-016 Port: dev_req, output, 1 bit; access request to the selected device.
REQ-017 Port: dev_we, output, 1 bit; 1=write, 0=read.
REQ-018 Port: dev_addr, output, 4 bits; register offset within the device.
REQ-019 Port: dev_wdata, output, 32 bits; latched store data.
REQ-020 Port: io_err, output, 1 bit; sticky error flag covering unmapped address, timeout, and simultaneous read/write.

Function
REQ-021 The FSM SHALL have exactly three states, IDLE, ACCESS and DONE, with 2-bit state encoding.
REQ-022 In IDLE, with IORead^IOWrite=1 and io_addr[7:4]<NDEV, the block SHALL do all of the following at the next edge:
- latch io_addr[3:0] into dev_addr, io_wdata into dev_wdata, and IOWrite into dev_we;
- latch the one-hot decode of io_addr[7:4] into dev_sel;
- clear the timeout counter;
- go to ACCESS.
REQ-023 In IDLE, with IORead^IOWrite=1 and io_addr[7:4]>=NDEV (unmapped), the block SHALL go to DONE, set io_rdata=0, set io_err=1, and issue no dev_req.
REQ-024 In IDLE, with IORead=IOWrite=1, the block SHALL treat the request as unmapped: go to DONE, io_rdata=0, io_err=1.
REQ-025 stall SHALL be combinational: 1 when (IDLE and (IORead|IOWrite)) or ACCESS; 0 in DONE and in idle-without-request.
REQ-026 dev_req SHALL equal 1 exactly while in ACCESS; dev_sel, dev_we, dev_addr and dev_wdata SHALL stay stable throughout ACCESS.
REQ-027 In ACCESS, when dev_ack=1, the block SHALL go to DONE; on a read it SHALL latch dev_rdata into io_rdata; on a write io_rdata SHALL keep its value.
REQ-028 The ACCESS-cycle counter SHALL be 5 bits; when it reaches TIMEOUT-1 with dev_ack=0, the block SHALL go to DONE with io_rdata=0 and io_err=1.
REQ-029 If dev_ack=1 in the same cycle as the timeout condition, dev_ack SHALL win and io_err SHALL NOT be set.
REQ-030 DONE SHALL last exactly one cycle with io_rdata_valid=1 and stall=0, then go unconditionally to IDLE; IORead/IOWrite sampled in DONE SHALL be ignored.
REQ-031 dev_ack SHALL be ignored in IDLE and DONE.
REQ-032 dev_sel SHALL be all-zero outside ACCESS.
REQ-033 err_clr=1 SHALL clear io_err at the next edge; if err_clr=1 and a new error event occur in the same cycle, the set SHALL win.
REQ-034 Latency: a mapped access whose device acks in its k-th ACCESS cycle SHALL take k+1 stall cycles, with io_rdata_valid on cycle k+2.

Reset
REQ-035 On reset=1 at a clock edge, the block SHALL return to IDLE and set these values from the next cycle: stall=0 (when no request), io_rdata=0, io_rdata_valid=0, dev_sel=0, dev_req=0, dev_we=0, dev_addr=0, dev_wdata=0, io_err=0, counter=0.
REQ-036 A reset during ACCESS SHALL abort the access: dev_req=0 on the cycle after the edge, with no io_rdata_valid pulse.

Verification
REQ-037 Mapped read: IORead=1, io_addr=8'h12, dev_ack=1 on the 2nd ACCESS cycle with dev_rdata=32'hA5A5_0001 -> dev_sel=4'b0010, dev_addr=4'h2, stall for 3 cycles, then io_rdata=32'hA5A5_0001 with io_rdata_valid=1 for 1 cycle.
REQ-038 Mapped write: IOWrite=1, io_addr=8'h30, io_wdata=32'h0000_FFFF, immediate ack -> dev_we=1, dev_sel=4'b1000, dev_wdata=32'h0000_FFFF, 2 stall cycles, io_err=0.
REQ-039 Timeout: IORead=1, io_addr=8'h00, dev_ack held 0 -> dev_req high for exactly 16 cycles, then DONE with io_rdata=0 and io_err=1; err_clr pulse -> io_err=0.
REQ-040 Unmapped address and simultaneous read/write: io_addr=8'h50, or IORead=IOWrite=1 -> no dev_req, stall 1 cycle, DONE, io_err=1.
REQ-041 Ack at the timeout boundary: dev_ack=1 on the 16th ACCESS cycle -> data latched, io_err stays 0.
REQ-042 Reset mid-access: reset=1 on the 3rd ACCESS cycle -> next cycle dev_req=0, IDLE, io_err=0, and no io_rdata_valid pulse.
